// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, state encoding and width helper for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a single-nibble counter still has a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// 4-bit carry-lookahead adder slice; also exports the carry into bit 3 for overflow.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract processed one nibble per cycle through a single CLA slice.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = clog2_min1(NIB);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NIB - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [3:0] slice_s;
  logic       slice_cout;
  logic       slice_c3;

  cla4_slice u_slice (
    .a    (a_q[idx_q*NIB_W +: NIB_W]),
    .b    (b_q[idx_q*NIB_W +: NIB_W]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
            sum     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum[idx_q*NIB_W +: NIB_W] <= slice_s;
          carry_q                   <= slice_cout;
          if (idx_q == LastIdx) begin
            cout    <= slice_cout;
            ovf     <= slice_cout ^ slice_c3;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .sub       (sub4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .ovf       (ovf4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid after an accept edge; checks latency.
  task automatic wait_result16(input string name, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
  endtask

  task automatic op16(input vec_t v, input string name);
    int w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({name, " in_ready before accept"}, in_ready, 1);
    a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({name, " in_ready after accept"}, in_ready, 0);
    wait_result16(name, 4);
    check({name, " sum"}, sum, v.sum);
    check({name, " cout"}, cout, v.cout);
    check({name, " ovf"}, ovf, v.ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid drop"}, out_valid, 0);
    check({name, " in_ready return"}, in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    in_valid = 0; a = '0; b = '0; sub = 0; out_ready = 0;
    in_valid4 = 0; a4 = '0; b4 = '0; sub4 = 0; out_ready4 = 0;

    #12;
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) op16(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready low, new request parked on the inputs.
    a = 16'h1234; b = 16'h0FCD; sub = 0; in_valid = 1'b1;
    tick();
    a = 16'h0003; b = 16'h0004;
    wait_result16("bp first", 4);
    for (int i = 0; i < 10; i++) begin
      check("bp sum held", sum, 16'h2201);
      check("bp in_ready low", in_ready, 0);
      check("bp out_valid held", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp in_ready after handshake", in_ready, 1);
    check("bp out_valid after handshake", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("bp accepted next edge", in_ready, 0);
    wait_result16("bp second", 4);
    check("bp second sum", sum, 16'h0007);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset after nibble 1 of an operation in flight.
    a = 16'h1234; b = 16'h0FCD; sub = 0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrun rst sum", sum, 0);
    check("midrun rst cout", cout, 0);
    check("midrun rst ovf", ovf, 0);
    check("midrun rst out_valid", out_valid, 0);
    check("midrun rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    op16('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0}, "post reset");

    // WIDTH=4: single RUN cycle.
    a4 = 4'h9; b4 = 4'h8; sub4 = 0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("w4 in_ready after accept", in_ready4, 0);
    check("w4 no early valid", out_valid4, 0);
    tick();
    check("w4 out_valid", out_valid4, 1);
    check("w4 sum", sum4, 4'h1);
    check("w4 cout", cout4, 1);
    check("w4 ovf", ovf4, 1);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("w4 in_ready return", in_ready4, 1);
    a4 = 4'h3; b4 = 4'h5; sub4 = 1; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    check("w4 sub out_valid", out_valid4, 1);
    check("w4 sub sum", sum4, 4'hE);
    check("w4 sub cout", cout4, 0);
    check("w4 sub ovf", ovf4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
